// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch/execute sequencer for the 4-bit CPU. Holds the program counter,
// addresses the instruction ROM, latches the instruction word and issues a
// one-cycle execute strobe. Resolves the next PC (increment, jump,
// jump-on-no-carry), supports free-run and single-step, and halts on a
// self-jump.
//
// Ports:
//   clk_i        system clock, all state on rising edge
//   reset_i      synchronous active-high reset, highest priority
//   run_i        level, 1 = free-run instruction cycles
//   step_req_i   starts exactly one instruction when idle and run_i=0
//   instr_i      ROM data for rom_addr_o (combinational, valid same cycle)
//   carry_i      datapath carry flag, sampled during EXEC
//   rom_addr_o   ROM address (equals pc_o)
//   pc_o         program counter
//   ir_op_o      latched opcode
//   ir_imm_o     latched immediate
//   exec_en_o    one-cycle execute strobe for the datapath
//   step_ack_o   one-cycle pulse when a single-step instruction completes
//   busy_o       1 while fetching or executing
//   halted_o     1 once halted on a self-jump
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int         PC_W             = 4,
  parameter logic [3:0] OP_JMP           = 4'b1111,
  parameter logic [3:0] OP_JNC           = 4'b1110,
  parameter bit         HALT_ON_SELF_JMP = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              step_req_i,
  input  logic [4+PC_W-1:0] instr_i,
  input  logic              carry_i,
  output logic [PC_W-1:0]   rom_addr_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [3:0]        ir_op_o,
  output logic [PC_W-1:0]   ir_imm_o,
  output logic              exec_en_o,
  output logic              step_ack_o,
  output logic              busy_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      ir_op_q, ir_op_d;
  logic [PC_W-1:0] ir_imm_q, ir_imm_d;
  logic            step_mode_q, step_mode_d;
  logic            exec_en_q, exec_en_d;
  logic            step_ack_q, step_ack_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic            self_jmp_s;

  // A jump to its own address is a halt request (JNC never counts).
  assign self_jmp_s = HALT_ON_SELF_JMP && (ir_op_q == OP_JMP) && (ir_imm_q == pc_q);

  // Next-state, next-PC and next-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_op_d     = ir_op_q;
    ir_imm_d    = ir_imm_q;
    step_mode_d = step_mode_q;
    step_ack_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step_req_i) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_FETCH: begin
        ir_op_d  = instr_i[4+PC_W-1:PC_W];
        ir_imm_d = instr_i[PC_W-1:0];
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        // Wraps naturally modulo 2^PC_W.
        if (ir_op_q == OP_JMP) begin
          pc_d = ir_imm_q;
        end else if ((ir_op_q == OP_JNC) && !carry_i) begin
          pc_d = ir_imm_q;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
        step_ack_d  = step_mode_q;
        step_mode_d = 1'b0;
        if (self_jmp_s) begin
          state_d = S_HALT;
        end else if (run_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    exec_en_d = (state_d == S_EXEC);
    busy_d    = (state_d == S_FETCH) || (state_d == S_EXEC);
    halted_d  = (state_d == S_HALT);
  end

  // State, PC, instruction and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_op_q     <= 4'd0;
      ir_imm_q    <= '0;
      step_mode_q <= 1'b0;
      exec_en_q   <= 1'b0;
      step_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_op_q     <= ir_op_d;
      ir_imm_q    <= ir_imm_d;
      step_mode_q <= step_mode_d;
      exec_en_q   <= exec_en_d;
      step_ack_q  <= step_ack_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign rom_addr_o = pc_q;
  assign pc_o       = pc_q;
  assign ir_op_o    = ir_op_q;
  assign ir_imm_o   = ir_imm_q;
  assign exec_en_o  = exec_en_q;
  assign step_ack_o = step_ack_q;
  assign busy_o     = busy_q;
  assign halted_o   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. A behavioural instruction-timeline model
// predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, step_req, carry;
  logic [7:0] instr;
  logic [3:0] rom_addr, pc, ir_op, ir_imm;
  logic       exec_en, step_ack, busy, halted;

  logic [7:0] rom [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign instr = rom[rom_addr];

  pc_sequencer dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .run_i      (run),
    .step_req_i (step_req),
    .instr_i    (instr),
    .carry_i    (carry),
    .rom_addr_o (rom_addr),
    .pc_o       (pc),
    .ir_op_o    (ir_op),
    .ir_imm_o   (ir_imm),
    .exec_en_o  (exec_en),
    .step_ack_o (step_ack),
    .busy_o     (busy),
    .halted_o   (halted)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An instruction is tracked by how far it has progressed: 0 = none in
  // flight, 1 = fetching, 2 = executing.
  int  m_pc, m_prog, m_op, m_imm;
  bit  m_halted, m_stepping, m_ack, m_valid;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_prog = 0; m_op = 0; m_imm = 0;
      m_halted = 0; m_stepping = 0; m_ack = 0; m_valid = 1;
    end else if (m_valid) begin
      m_ack = 0;
      if (m_halted) begin
        // frozen until reset
      end else if (m_prog == 0) begin
        if (run) begin m_prog = 1; m_stepping = 0; end
        else if (step_req) begin m_prog = 1; m_stepping = 1; end
      end else if (m_prog == 1) begin
        m_op  = rom[m_pc] >> 4;
        m_imm = rom[m_pc] & 15;
        m_prog = 2;
      end else begin
        m_ack = m_stepping;
        m_stepping = 0;
        if (m_op == 15 && m_imm == m_pc) begin
          m_halted = 1;
          m_prog = 0;
        end else begin
          if (m_op == 15 || (m_op == 14 && carry == 1'b0)) m_pc = m_imm;
          else m_pc = (m_pc + 1) % 16;
          m_prog = run ? 1 : 0;
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("pc",       pc,       m_pc);
      chk("rom_addr", rom_addr, m_pc);
      chk("ir_op",    ir_op,    m_op);
      chk("ir_imm",   ir_imm,   m_imm);
      chk("exec_en",  exec_en,  int'(m_prog == 2));
      chk("step_ack", step_ack, int'(m_ack));
      chk("busy",     busy,     int'(m_prog != 0));
      chk("halted",   halted,   int'(m_halted));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset();
    @(negedge clk); reset = 1'b1; run = 1'b0; step_req = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic step_once();
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic stop_run();
    @(negedge clk); run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n_exec, n_ack;
    reset = 1'b1; run = 1'b0; step_req = 1'b0; carry = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_exec", exec_en, 0);
    chk("rst_ack", step_ack, 0);
    reset = 1'b0;

    // Free run over all-zero ROM: exec every 2nd cycle, pc wraps to 0.
    @(negedge clk); run = 1'b1;
    n_exec = 0; n_ack = 0;
    repeat (33) begin
      @(posedge clk); #1;
      if (exec_en) n_exec++;
      if (step_ack) n_ack++;
    end
    chk("run_exec_count", n_exec, 16);
    chk("run_wrap_pc", pc, 0);
    chk("run_no_ack", n_ack, 0);
    stop_run();

    // Single step latency from pc=3.
    do_reset();
    repeat (3) step_once();
    chk("step_pc3", pc, 3);
    @(negedge clk); step_req = 1'b1;
    @(posedge clk); #1;
    chk("step_fetch_busy", busy, 1);
    chk("step_fetch_exec", exec_en, 0);
    @(negedge clk); step_req = 1'b0;
    @(posedge clk); #1;
    chk("step_exec", exec_en, 1);
    @(posedge clk); #1;
    chk("step_pc4", pc, 4);
    chk("step_ack", step_ack, 1);
    chk("step_done_busy", busy, 0);
    @(posedge clk); #1;
    chk("step_ack_once", step_ack, 0);
    repeat (4) @(negedge clk);
    chk("step_idle_pc", pc, 4);
    chk("step_idle_busy", busy, 0);

    // Unconditional jump at addr 2 to 7.
    rom[2] = 8'hF7;
    do_reset();
    @(negedge clk); run = 1'b1;
    repeat (6) @(posedge clk); #1;
    chk("jmp_op", ir_op, 15);
    chk("jmp_imm", ir_imm, 7);
    @(posedge clk); #1;
    chk("jmp_pc", pc, 7);
    stop_run();
    rom[2] = 8'h00;

    // JNC at addr 5 with carry set, then clear.
    rom[5] = 8'hE9;
    carry = 1'b1;
    do_reset();
    @(negedge clk); run = 1'b1;
    repeat (13) @(posedge clk); #1;
    chk("jnc_carry1_pc", pc, 6);
    stop_run();
    carry = 1'b0;
    do_reset();
    @(negedge clk); run = 1'b1;
    repeat (13) @(posedge clk); #1;
    chk("jnc_carry0_pc", pc, 9);
    stop_run();
    rom[5] = 8'h00;

    // Self-jump at addr 4 halts; controls ignored until reset.
    rom[4] = 8'hF4;
    do_reset();
    @(negedge clk); run = 1'b1;
    repeat (11) @(posedge clk); #1;
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 4);
    chk("halt_busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); run = i[0]; step_req = i[1];
    end
    @(negedge clk); run = 1'b0; step_req = 1'b0;
    chk("halt_hold", halted, 1);
    chk("halt_hold_pc", pc, 4);
    do_reset();
    chk("halt_reset_pc", pc, 0);
    chk("halt_reset_flag", halted, 0);
    rom[4] = 8'h00;

    // Reset during a stepped EXEC abandons it.
    do_reset();
    repeat (2) step_once();
    @(negedge clk); step_req = 1'b1;
    @(negedge clk); step_req = 1'b0;
    @(posedge clk); #1;
    chk("rexec_exec", exec_en, 1);
    chk("rexec_pc_before", pc, 2);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rexec_pc", pc, 0);
    chk("rexec_exec0", exec_en, 0);
    chk("rexec_ack0", step_ack, 0);
    chk("rexec_busy0", busy, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rexec_no_ack", step_ack, 0);

    // run with step_req: free-run, never acknowledged.
    @(negedge clk); run = 1'b1; step_req = 1'b1;
    n_ack = 0; n_exec = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (step_ack) n_ack++;
      if (exec_en) n_exec++;
    end
    chk("runstep_no_ack", n_ack, 0);
    chk("runstep_exec", n_exec, 5);
    @(negedge clk); run = 1'b0; step_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
